dmem_responder: RTL and testbench

Data-memory responder for the single-cycle/multi-cycle RISC-V core. It is the target side of the load/store control path. It accepts the decoder's `MemRead`/`MemWrite` strobes together with the ALU-computed address and the store data. It serves each access after a fixed number of wait states and holds the pipeline with `stall` until the access completes. It sits between the execute stage and the writeback mux, and its read data feeds the `MemToReg` path.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_array.sv | 27 ++
 rtl/dmem_responder.sv | 163 ++++++++++++++++
 tb/tb_dmem_responder.sv | 118 +++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int unsigned XLEN = 32;

    // Latched operation encoding; a simultaneous read+write is stored as a write.
    localparam logic DMEM_OP_RD = 1'b0;
    localparam logic DMEM_OP_WR = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

endpackage : dmem_pkg

// File: rtl/dmem_responder_if.sv
// Load/store bus between the core (master) and the data-memory responder (slave).
interface dmem_responder_if;
    import dmem_pkg::*;

    logic            mem_read;
    logic            mem_write;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rdata;
    logic            rvalid;
    logic            stall;
    logic            err;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, rvalid, stall, err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, rvalid, stall, err
    );

endinterface : dmem_responder_if

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM; read port only updates on re, no reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic                           re,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [XLEN-1:0]                din,
    output logic [XLEN-1:0]                dout
);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    // Write and registered read share the single address port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= din;
        end
        if (re) begin
            dout <= mem[idx];
        end
    end

endmodule : dmem_array

// File: rtl/dmem_responder.sv
// Data-memory responder: serves loads/stores after WAIT_STATES busy cycles,
// holding the pipeline with stall. Optional misalignment check is enabled by
// defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_responder_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

    dmem_state_t state_q, state_n;

    logic [CNT_W-1:0] cnt_q;
    logic             op_q;
    logic [IDX_W-1:0] idx_q;
    logic [XLEN-1:0]  wdata_q;

    logic             req_c;
    logic             stall_c;
    logic             latch_c;
    logic             commit_c;
    logic             misalign_c;

    logic             rvalid_q;
    logic             err_q;
    logic             rzero_q;

    logic             ram_we;
    logic             ram_re;
    logic [XLEN-1:0]  ram_dout;

    assign req_c = bus.mem_read | bus.mem_write;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE: if (req_c) state_n = BUSY;
            BUSY: if (cnt_q == '0) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Per-state control: stall, request capture and commit strobe.
    always_comb begin
        stall_c  = 1'b0;
        latch_c  = 1'b0;
        commit_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall_c = req_c;
                latch_c = req_c;
            end
            BUSY: begin
                stall_c  = 1'b1;
                commit_c = (cnt_q == '0);
            end
            DONE: ;
            default: ;
        endcase
    end

    // Stall drops as soon as reset asserts, even with a request still held.
    assign bus.stall = rst_n & stall_c;

    // Request capture and wait-state counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            op_q    <= DMEM_OP_RD;
            idx_q   <= '0;
            wdata_q <= '0;
        end else if (latch_c) begin
            cnt_q   <= CNT_W'(WAIT_STATES - 1);
            op_q    <= bus.mem_write ? DMEM_OP_WR : DMEM_OP_RD;
            idx_q   <= bus.addr[IDX_W+1:2];
            wdata_q <= bus.wdata;
        end else if (state_q == BUSY && cnt_q != '0) begin
            cnt_q   <= cnt_q - CNT_W'(1);
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic [1:0] lo_q;

    // Byte-offset bits of the latched address for the alignment check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q <= 2'b00;
        end else if (latch_c) begin
            lo_q <= bus.addr[1:0];
        end
    end

    assign misalign_c = (lo_q != 2'b00);

    logic unused_addr;
    assign unused_addr = ^bus.addr[XLEN-1:IDX_W+2];
`else
    assign misalign_c = 1'b0;

    logic unused_addr;
    assign unused_addr = ^{bus.addr[XLEN-1:IDX_W+2], bus.addr[1:0]};
`endif

    assign ram_we = commit_c & (op_q == DMEM_OP_WR) & ~misalign_c;
    assign ram_re = commit_c & (op_q == DMEM_OP_RD) & ~misalign_c;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .we   (ram_we),
        .re   (ram_re),
        .idx  (idx_q),
        .din  (wdata_q),
        .dout (ram_dout)
    );

    // Response flags for the DONE cycle; rzero_q masks the unreset RAM output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rzero_q  <= 1'b1;
        end else begin
            rvalid_q <= ram_re;
            err_q    <= commit_c & misalign_c;
            if (commit_c && op_q == DMEM_OP_RD) begin
                rzero_q <= misalign_c;
            end
        end
    end

    assign bus.rdata  = rzero_q ? '0 : ram_dout;
    assign bus.rvalid = rvalid_q;
`ifdef DMEM_ALIGN_CHECK_EN
    assign bus.err    = err_q;
`else
    assign bus.err    = 1'b0;

    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH_WORDS=256, WAIT_STATES=2).
`timescale 1ns/1ps
module tb_dmem_responder;

    logic clk;
    logic rst_n;
    int   checks;
    int   fails;

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH_WORDS (256),
        .WAIT_STATES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One access: present request, count stall cycles, check the DONE cycle
    // and the idle cycle after it.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic exp_rvalid, input logic exp_err,
                          input logic [31:0] exp_rdata);
        int n;
        @(posedge clk); #1;
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.addr      = a;
        bus.wdata     = d;
        @(negedge clk);
        n = 0;
        while (bus.stall === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        chk({tag, "_stall_cycles"}, 32'(n), 32'd3);
        chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'(exp_rvalid));
        chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        chk({tag, "_rdata"}, bus.rdata, exp_rdata);
        @(negedge clk);
        chk({tag, "_idle_pulse"}, 32'({bus.stall, bus.rvalid, bus.err}), 32'd0);
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst_n         = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
        #7;
        chk("rst_stall",  32'(bus.stall),  32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_err",    32'(bus.err),    32'd0);
        chk("rst_rdata",  bus.rdata,       32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        access("wr10",  1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
        access("rd10",  1'b1, 1'b0, 32'h10,  32'h0,        1'b1, 1'b0, 32'hDEADBEEF);
        access("wr00",  1'b0, 1'b1, 32'h0,   32'h12345678, 1'b0, 1'b0, 32'hDEADBEEF);
        access("rd400", 1'b1, 1'b0, 32'h400, 32'h0,        1'b1, 1'b0, 32'h12345678);
        access("both20",1'b1, 1'b1, 32'h20,  32'hA5A5A5A5, 1'b0, 1'b0, 32'h12345678);
        access("rd20",  1'b1, 1'b0, 32'h20,  32'h0,        1'b1, 1'b0, 32'hA5A5A5A5);
        access("wr30",  1'b0, 1'b1, 32'h30,  32'h77,       1'b0, 1'b0, 32'hA5A5A5A5);

        // Reset during BUSY of a write to 0x30.
        @(posedge clk); #1;
        bus.mem_write = 1'b1;
        bus.addr      = 32'h30;
        bus.wdata     = 32'h1;
        @(posedge clk); #1;
        chk("midrst_busy_stall", 32'(bus.stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_stall",  32'(bus.stall),  32'd0);
        chk("midrst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("midrst_rdata",  bus.rdata,       32'd0);
        bus.mem_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        access("rd30",  1'b1, 1'b0, 32'h30,  32'h0,        1'b1, 1'b0, 32'h77);

`ifdef DMEM_ALIGN_CHECK_EN
        access("rd13",  1'b1, 1'b0, 32'h13,  32'h0,        1'b0, 1'b1, 32'h0);
        access("wr14",  1'b0, 1'b1, 32'h14,  32'h55,       1'b0, 1'b0, 32'h0);
        access("wr16",  1'b0, 1'b1, 32'h16,  32'h99,       1'b0, 1'b1, 32'h0);
        access("rd14",  1'b1, 1'b0, 32'h14,  32'h0,        1'b1, 1'b0, 32'h55);
`else
        access("rd13",  1'b1, 1'b0, 32'h13,  32'h0,        1'b1, 1'b0, 32'hDEADBEEF);
        access("wr14",  1'b0, 1'b1, 32'h14,  32'h55,       1'b0, 1'b0, 32'hDEADBEEF);
        access("wr16",  1'b0, 1'b1, 32'h16,  32'h99,       1'b0, 1'b0, 32'hDEADBEEF);
        access("rd14",  1'b1, 1'b0, 32'h14,  32'h0,        1'b1, 1'b0, 32'h99);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_dmem_responder
